mmio_resp: RTL



---
 rtl/mmio_resp_if.sv | 22 ++
 rtl/mmio_resp.sv | 111 +++++++++++
 2 files changed

// File: rtl/mmio_resp_if.sv
// Core data-bus port and FIFO drain stream for the mmio_resp block.
// slave = the responder, master = the core plus the downstream consumer.
interface mmio_resp_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output readdata, sel, out_data, out_valid
  );

  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  readdata, sel, out_data, out_valid
  );
endinterface

// File: rtl/mmio_resp.sv
// MMIO responder: STATUS / TXDATA (FIFO push) / CYCLE / SCRATCH in a 16-byte window.
// Define MMIO_CYCLE_CNT_EN to build the free-running CYCLE counter; otherwise CYCLE reads 0.
module mmio_resp #(
  parameter logic [31:0] BASE  = 32'h0000_FF00,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  mmio_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    R_STATUS  = 2'd0,
    R_TXDATA  = 2'd1,
    R_CYCLE   = 2'd2,
    R_SCRATCH = 2'd3
  } reg_e;

  reg_e                   off;
  logic                   wr;
  logic                   empty, full;
  logic                   push_req, push, pop;
  logic                   ovf_set, ovf_clr;
  logic [AW-1:0]          rptr, wptr;
  logic [CW-1:0]          count;
  logic                   ovf;
  logic [31:0]            scratch;
  logic [31:0]            status;
  logic [31:0]            cyc_rd;
  logic [DEPTH-1:0][31:0] mem;
  logic                   unused_bits;

  assign unused_bits = ^bus.dataadr[1:0];

  assign off     = reg_e'(bus.dataadr[3:2]);
  assign bus.sel = (bus.dataadr[31:4] == BASE[31:4]);
  assign wr      = bus.memwrite && bus.sel;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // out_valid depends only on registered count, never on this cycle's strobes
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rptr];

  assign pop      = bus.out_valid && bus.out_ready;
  assign push_req = wr && (off == R_TXDATA);
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr && (off == R_STATUS) && bus.writedata[8];

  assign status = {23'd0, ovf, 6'(count), full, empty};

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      scratch <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (wr && (off == R_SCRATCH)) scratch <= bus.writedata;
    end
  end

  // storage needs no reset: entries are only visible through count
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr] <= bus.writedata;
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset)                     cyc_q <= '0;
    else if (wr && (off == R_CYCLE)) cyc_q <= bus.writedata;
    else                           cyc_q <= cyc_q + 32'd1;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  always_comb begin
    bus.readdata = '0;
    if (bus.sel) begin
      case (off)
        R_STATUS:  bus.readdata = status;
        R_TXDATA:  bus.readdata = '0;
        R_CYCLE:   bus.readdata = cyc_rd;
        R_SCRATCH: bus.readdata = scratch;
        default:   bus.readdata = '0;
      endcase
    end
  end

endmodule
